cavlc_coeff_builder: RTL and testbench

CAVLC_COEFF_BUILDER -- requirements
Module: cavlc_coeff_builder

---
 rtl/cavlc_coeff_builder.sv | 185 ++++++++++++++++++
 tb/tb_cavlc_coeff_builder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_builder.sv
// cavlc_coeff_builder: collects CAVLC levels and run_before values for one block,
// places them into scan positions, then streams the coefficients in scan order
// with a valid/ready handshake.
// Optional feature: define CAVLC_COEFF_ERR_CHK_EN to enable the TotalCoeff/TotalZeros
// consistency checks and the sticky err flag; otherwise err is tied low and the
// placement position simply wraps modulo 16.
module cavlc_coeff_builder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       start,
   input  logic [4:0] max_coeff_num,
   input  logic [4:0] TotalCoeff,
   input  logic [3:0] TotalZeros,
   input  logic       level_we,
   input  logic [3:0] level_idx,
   input  logic [8:0] level_val,
   input  logic       run_we,
   input  logic [3:0] run_idx,
   input  logic [3:0] run_val,
   input  logic       done_in,
   output logic       coeff_valid,
   output logic [8:0] coeff_data,
   output logic [3:0] coeff_pos,
   output logic       coeff_last,
   input  logic       coeff_ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PLACE, S_OUTPUT} state_t;

   state_t            state_q;
   // Levels are stored as raw two's-complement bits; they are only moved, never summed.
   logic [15:0][8:0]  level_q;
   logic [15:0][3:0]  run_q;
   logic [15:0][8:0]  coef_q;
   logic [4:0]        tc_q;
   logic [4:0]        max_q;
   logic [4:0]        k_q;
   logic [5:0]        pos_q;
   logic              valid_q;
   logic [8:0]        data_q;
   logic [3:0]        cpos_q;
   logic              last_q;

   logic [5:0]        tcz_d;
   logic [5:0]        step_d;
   logic [5:0]        pos_d;
   logic              last_k_d;
   logic [8:0]        first_d;
   logic [3:0]        nxt_pos_d;

`ifdef CAVLC_COEFF_ERR_CHK_EN
   logic              err_q;
   logic              bad_done_d;
   logic              bad_place_d;
`endif

   // Placement arithmetic, first-coefficient bypass and next stream index.
   always_comb begin
      tcz_d     = {1'b0, TotalCoeff} + {2'b00, TotalZeros};
      step_d    = {2'b00, run_q[k_q[3:0]]} + 6'd1;
      pos_d     = pos_q - step_d;
      last_k_d  = (k_q == tc_q - 5'd1);
      // The final PLACE cycle may be writing coef[0] on the same edge that loads it.
      first_d   = (pos_q[3:0] == 4'd0) ? level_q[k_q[3:0]] : coef_q[0];
      nxt_pos_d = cpos_q + 4'd1;
`ifdef CAVLC_COEFF_ERR_CHK_EN
      bad_done_d  = (tcz_d > {1'b0, max_coeff_num}) || (TotalCoeff > max_coeff_num);
      bad_place_d = !last_k_d && (pos_q < step_d);
`endif
   end

   // Block FSM: collect, place, stream; start aborts anything and clears the buffers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         level_q <= '0;
         run_q   <= '0;
         coef_q  <= '0;
         tc_q    <= '0;
         max_q   <= '0;
         k_q     <= '0;
         pos_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cpos_q  <= '0;
         last_q  <= 1'b0;
`ifdef CAVLC_COEFF_ERR_CHK_EN
         err_q   <= 1'b0;
`endif
      end else if (ena) begin
         if (start) begin
            state_q <= S_COLLECT;
            level_q <= '0;
            run_q   <= '0;
            coef_q  <= '0;
            k_q     <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cpos_q  <= '0;
            last_q  <= 1'b0;
`ifdef CAVLC_COEFF_ERR_CHK_EN
            err_q   <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_COLLECT: begin
                  if (level_we) level_q[level_idx] <= level_val;
                  if (run_we)   run_q[run_idx]     <= run_val;
                  if (done_in) begin
                     tc_q  <= TotalCoeff;
                     max_q <= max_coeff_num;
                     k_q   <= '0;
                     pos_q <= tcz_d - 6'd1;
`ifdef CAVLC_COEFF_ERR_CHK_EN
                     if (bad_done_d) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                     end else if (TotalCoeff == 5'd0) begin
`else
                     if (TotalCoeff == 5'd0) begin
`endif
                        state_q <= S_OUTPUT;
                        valid_q <= 1'b1;
                        cpos_q  <= '0;
                        data_q  <= coef_q[0];
                        last_q  <= (max_coeff_num == 5'd1);
                     end else begin
                        state_q <= S_PLACE;
                     end
                  end
               end
               S_PLACE: begin
                  coef_q[pos_q[3:0]] <= level_q[k_q[3:0]];
                  pos_q <= pos_d;
                  k_q   <= k_q + 5'd1;
`ifdef CAVLC_COEFF_ERR_CHK_EN
                  if (bad_place_d) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (last_k_d) begin
`else
                  if (last_k_d) begin
`endif
                     state_q <= S_OUTPUT;
                     valid_q <= 1'b1;
                     cpos_q  <= '0;
                     data_q  <= first_d;
                     last_q  <= (max_q == 5'd1);
                  end
               end
               S_OUTPUT: begin
                  if (valid_q && coeff_ready) begin
                     if (last_q) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                     end else begin
                        cpos_q <= nxt_pos_d;
                        data_q <= coef_q[nxt_pos_d];
                        last_q <= ({1'b0, nxt_pos_d} == max_q - 5'd1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign coeff_valid = valid_q;
   assign coeff_data  = data_q;
   assign coeff_pos   = cpos_q;
   assign coeff_last  = last_q;
   assign busy        = (state_q != S_IDLE);
`ifdef CAVLC_COEFF_ERR_CHK_EN
   assign err         = err_q;
`else
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_cavlc_coeff_builder.sv
// Directed bench for cavlc_coeff_builder: a table of blocks with hand-computed
// coefficient streams, plus hand-written sequences for stalls, clock-enable gaps,
// start/reset aborts and the optional error checks.
module tb_cavlc_coeff_builder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       start;
   logic [4:0] max_coeff_num;
   logic [4:0] TotalCoeff;
   logic [3:0] TotalZeros;
   logic       level_we;
   logic [3:0] level_idx;
   logic [8:0] level_val;
   logic       run_we;
   logic [3:0] run_idx;
   logic [3:0] run_val;
   logic       done_in;
   logic       coeff_valid;
   logic [8:0] coeff_data;
   logic [3:0] coeff_pos;
   logic       coeff_last;
   logic       coeff_ready;
   logic       busy;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]       mx;
      logic [4:0]       tc;
      logic [3:0]       tz;
      logic [15:0][8:0] lv;
      logic [15:0][3:0] rn;
      logic [15:0][8:0] ex;
   } vec_t;

   vec_t vecs [6];
   vec_t ve;

   cavlc_coeff_builder dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .max_coeff_num(max_coeff_num), .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
      .level_we(level_we), .level_idx(level_idx), .level_val(level_val),
      .run_we(run_we), .run_idx(run_idx), .run_val(run_val), .done_in(done_in),
      .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_pos(coeff_pos),
      .coeff_last(coeff_last), .coeff_ready(coeff_ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] s9(input int v);
      return v[8:0];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Pulse start, write all levels/runs, with done_in on the final write.
   task automatic collect(input vec_t v, input string tag);
      max_coeff_num = v.mx;
      TotalCoeff    = v.tc;
      TotalZeros    = v.tz;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk({tag, " busy_after_start"}, int'(busy), 1);
      chk({tag, " valid_after_start"}, int'(coeff_valid), 0);
      if (v.tc == 5'd0) begin
         done_in = 1'b1;
         cyc();
      end else begin
         for (int k = 0; k < int'(v.tc); k++) begin
            level_we  = 1'b1;
            level_idx = 4'(k);
            level_val = v.lv[k];
            run_we    = 1'b1;
            run_idx   = 4'(k);
            run_val   = v.rn[k];
            done_in   = (k == int'(v.tc) - 1);
            cyc();
         end
      end
      level_we = 1'b0;
      run_we   = 1'b0;
      done_in  = 1'b0;
   endtask

   // Collect then wait for the first coefficient, checking PLACE latency.
   task automatic load_block(input vec_t v, input bit gap, input string tag);
      int cnt;
      bit gdone;
      collect(v, tag);
      cnt = 0;
      gdone = 1'b0;
      while (!coeff_valid && cnt < 40) begin
         if (gap && !gdone && cnt == 1) begin
            ena = 1'b0;
            repeat (5) begin
               cyc();
               chk({tag, " place_gap_valid"}, int'(coeff_valid), 0);
               chk({tag, " place_gap_busy"}, int'(busy), 1);
            end
            ena = 1'b1;
            gdone = 1'b1;
         end
         cnt++;
         cyc();
      end
      chk({tag, " place_latency"}, cnt, int'(v.tc));
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: ena gap at pos 2.
   task automatic stream_block(input vec_t v, input int mode, input string tag);
      int j;
      int ph;
      bit gdone;
      logic rdy;
      j = 0;
      ph = 0;
      gdone = 1'b0;
      while (j < int'(v.mx) && ph < 200) begin
         rdy = (mode == 1) ? (ph % 3 == 0) : 1'b1;
         coeff_ready = rdy;
         chk({tag, " valid"}, int'(coeff_valid), 1);
         chk({tag, " pos"}, int'(coeff_pos), j);
         chk({tag, " data"}, int'($signed(coeff_data)), int'($signed(v.ex[j])));
         chk({tag, " last"}, int'(coeff_last), int'(j == int'(v.mx) - 1));
         if (mode == 2 && j == 2 && !gdone) begin
            ena = 1'b0;
            repeat (5) begin
               cyc();
               chk({tag, " gap_valid"}, int'(coeff_valid), 1);
               chk({tag, " gap_pos"}, int'(coeff_pos), j);
               chk({tag, " gap_data"}, int'($signed(coeff_data)), int'($signed(v.ex[j])));
            end
            ena = 1'b1;
            gdone = 1'b1;
         end
         cyc();
         if (rdy) j++;
         ph++;
      end
      chk({tag, " stream_count"}, j, int'(v.mx));
      coeff_ready = 1'b0;
      chk({tag, " valid_after_last"}, int'(coeff_valid), 0);
      chk({tag, " busy_after_last"}, int'(busy), 0);
      chk({tag, " err_after_last"}, int'(err), 0);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; ena = 1'b1; start = 1'b0;
      max_coeff_num = 5'd16; TotalCoeff = '0; TotalZeros = '0;
      level_we = 1'b0; level_idx = '0; level_val = '0;
      run_we = 1'b0; run_idx = '0; run_val = '0;
      done_in = 1'b0; coeff_ready = 1'b0;

      // Block table with hand-derived scan-order results.
      for (int i = 0; i < 6; i++) vecs[i] = '0;
      vecs[0].mx = 5'd16; vecs[0].tc = 5'd3; vecs[0].tz = 4'd2;
      vecs[0].lv[0] = s9(1); vecs[0].lv[1] = s9(-1); vecs[0].lv[2] = s9(3);
      vecs[0].rn[0] = 4'd1;  vecs[0].rn[1] = 4'd0;   vecs[0].rn[2] = 4'd7;
      vecs[0].ex[1] = s9(3); vecs[0].ex[2] = s9(-1); vecs[0].ex[4] = s9(1);
      vecs[1].mx = 5'd16;
      vecs[2].mx = 5'd4; vecs[2].tc = 5'd4;
      for (int k = 0; k < 4; k++) begin
         vecs[2].lv[k]     = s9(5 + k);
         vecs[2].ex[3 - k] = s9(5 + k);
      end
      vecs[3].mx = 5'd8; vecs[3].tc = 5'd2; vecs[3].tz = 4'd3;
      vecs[3].lv[0] = s9(-2); vecs[3].lv[1] = s9(255);
      vecs[3].rn[0] = 4'd3;   vecs[3].rn[1] = 4'd5;
      vecs[3].ex[0] = s9(255); vecs[3].ex[4] = s9(-2);
      vecs[4].mx = 5'd16; vecs[4].tc = 5'd16;
      for (int k = 0; k < 16; k++) begin
         vecs[4].lv[k] = s9(k + 1);
         vecs[4].ex[k] = s9(16 - k);
      end
      vecs[4].lv[0] = s9(-256); vecs[4].ex[15] = s9(-256);
      vecs[5].mx = 5'd1; vecs[5].tc = 5'd1;
      vecs[5].lv[0] = s9(9); vecs[5].ex[0] = s9(9);

      cyc();
      cyc();
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(coeff_valid), 0);
      chk("reset last", int'(coeff_last), 0);
      chk("reset data", int'(coeff_data), 0);
      chk("reset pos", int'(coeff_pos), 0);
      chk("reset err", int'(err), 0);
      rst_n = 1'b1;
      cyc();

      // done_in while idle is ignored.
      TotalCoeff = 5'd0;
      done_in = 1'b1;
      cyc();
      done_in = 1'b0;
      chk("idle_done busy", int'(busy), 0);
      chk("idle_done valid", int'(coeff_valid), 0);

      for (int i = 0; i < 6; i++) begin
         load_block(vecs[i], 1'b0, $sformatf("vec%0d", i));
         stream_block(vecs[i], 0, $sformatf("vec%0d", i));
         cyc();
      end

      // Ready toggling 1,0,0: each position presented once, data held in stalls.
      load_block(vecs[0], 1'b0, "stall");
      stream_block(vecs[0], 1, "stall");

      // Clock-enable gaps in PLACE and OUTPUT give the same stream.
      load_block(vecs[0], 1'b1, "enagap");
      stream_block(vecs[0], 2, "enagap");

      // start in the middle of OUTPUT aborts and clears the arrays.
      load_block(vecs[0], 1'b0, "abort");
      coeff_ready = 1'b1;
      cyc();
      cyc();
      chk("abort pos_before", int'(coeff_pos), 2);
      chk("abort data_before", int'($signed(coeff_data)), -1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      coeff_ready = 1'b0;
      chk("abort valid", int'(coeff_valid), 0);
      chk("abort busy", int'(busy), 1);
      cyc();
      chk("abort still_stopped", int'(coeff_valid), 0);
      TotalCoeff = 5'd0;
      max_coeff_num = 5'd16;
      done_in = 1'b1;
      cyc();
      done_in = 1'b0;
      stream_block(vecs[1], 0, "after_abort");

      // Reset with ena=0 during OUTPUT: no handshake, everything cleared.
      load_block(vecs[0], 1'b0, "rstmid");
      coeff_ready = 1'b1;
      cyc();
      chk("rstmid pos_before", int'(coeff_pos), 1);
      ena = 1'b0;
      rst_n = 1'b0;
      cyc();
      chk("rstmid valid", int'(coeff_valid), 0);
      chk("rstmid busy", int'(busy), 0);
      chk("rstmid pos", int'(coeff_pos), 0);
      chk("rstmid data", int'(coeff_data), 0);
      chk("rstmid last", int'(coeff_last), 0);
      rst_n = 1'b1;
      ena = 1'b1;
      coeff_ready = 1'b0;
      cyc();

      // Inconsistent TotalCoeff/TotalZeros for the block size.
      ve = '0;
      ve.mx = 5'd15; ve.tc = 5'd10; ve.tz = 4'd6;
      collect(ve, "errdone");
`ifdef CAVLC_COEFF_ERR_CHK_EN
      chk("errdone err", int'(err), 1);
      chk("errdone busy", int'(busy), 0);
      seen = 1'b0;
      repeat (20) begin
         cyc();
         if (coeff_valid) seen = 1'b1;
      end
      chk("errdone never_valid", int'(seen), 0);
      chk("errdone err_sticky", int'(err), 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("errdone err_cleared", int'(err), 0);

      // A run that would push the position below zero.
      ve = '0;
      ve.mx = 5'd16; ve.tc = 5'd3; ve.tz = 4'd0;
      ve.lv[0] = s9(4); ve.lv[1] = s9(5); ve.lv[2] = s9(6);
      ve.rn[0] = 4'd2;
      collect(ve, "errplace");
      cyc();
      chk("errplace err", int'(err), 1);
      chk("errplace busy", int'(busy), 0);
      chk("errplace valid", int'(coeff_valid), 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("errplace err_cleared", int'(err), 0);
`else
      seen = 1'b0;
      chk("errdone err_tied", int'(err), 0);
      chk("errdone busy", int'(busy), 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("errdone restart_busy", int'(busy), 1);
      chk("errdone restart_valid", int'(coeff_valid) | int'(seen), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
